bp_me_nonsynth_mem_responder: RTL and testbench



---
 rtl/bp_me_nonsynth_mem_responder.sv | 142 ++++++++++++++
 tb/tb_bp_me_nonsynth_mem_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bp_me_nonsynth_mem_responder.sv
// Memory-side responder for the CCE memory interface: one outstanding command,
// serviced against a small internal block store after a fixed latency.
module bp_me_nonsynth_mem_responder
  #(parameter int paddr_width_p     = 40
   ,parameter int cce_block_width_p = 512
   ,parameter int lce_id_width_p    = 4
   ,parameter int lce_assoc_p       = 8
   ,parameter int mem_els_p         = 64
   ,parameter int latency_p         = 4
   ,localparam int way_id_width_lp      = $clog2(lce_assoc_p)
   ,localparam int cce_mem_msg_width_lp = cce_block_width_p + 4 + paddr_width_p + 3
                                          + lce_id_width_p + way_id_width_lp
   )
  (input  logic                            clk_i
  ,input  logic                            reset_n_i
  ,input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i
  ,input  logic                            mem_cmd_v_i
  ,output logic                            mem_cmd_ready_o
  ,output logic [cce_mem_msg_width_lp-1:0] mem_resp_o
  ,output logic                            mem_resp_v_o
  ,input  logic                            mem_resp_yumi_i
  );

  localparam int block_bytes_lp    = cce_block_width_p / 8;
  localparam int lg_block_bytes_lp = $clog2(block_bytes_lp);
  localparam int lg_els_lp         = $clog2(mem_els_p);
  localparam int cnt_w_lp          = $clog2(latency_p + 1);

  typedef enum logic [3:0] {
    e_mem_msg_rd    = 4'd0
   ,e_mem_msg_wr    = 4'd1
   ,e_mem_msg_uc_rd = 4'd2
   ,e_mem_msg_uc_wr = 4'd3
  } mem_msg_e;

  typedef struct packed {
    logic [lce_id_width_p-1:0]  lce_id;
    logic [way_id_width_lp-1:0] way_id;
  } payload_s;

  typedef struct packed {
    payload_s                 payload;
    logic [2:0]               size;
    logic [paddr_width_p-1:0] addr;
    mem_msg_e                 msg_type;
  } hdr_s;

  typedef struct packed {
    logic [cce_block_width_p-1:0] data;
    hdr_s                         header;
  } msg_s;

  typedef enum logic [1:0] {e_ready, e_wait, e_resp} state_e;

  state_e                 state_r, state_n;
  logic [cnt_w_lp-1:0]    cnt_r;
  msg_s                   cmd_r, resp_r, cmd_in;
  logic                   cmd_fire, service;

  // Store contents survive reset; only time-zero initialization clears them.
  logic [cce_block_width_p-1:0] mem_r [mem_els_p] = '{default: '0};

  assign cmd_in          = msg_s'(mem_cmd_i);
  assign mem_cmd_ready_o = reset_n_i & (state_r == e_ready);
  assign mem_resp_v_o    = (state_r == e_resp);
  assign mem_resp_o      = resp_r;
  assign cmd_fire        = mem_cmd_v_i & mem_cmd_ready_o;
  assign service         = (state_r == e_wait) & (cnt_r == '0);

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state_r <= e_ready;
    else            state_r <= state_n;

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_ready: if (cmd_fire)        state_n = e_wait;
      e_wait:  if (service)         state_n = e_resp;
      e_resp:  if (mem_resp_yumi_i) state_n = e_ready;
      default:                      state_n = e_ready;
    endcase
  end

  // Access datapath: everything is derived from the latched command.
  logic [lg_els_lp-1:0]         idx;
  logic [lg_block_bytes_lp-1:0] off;
  logic [block_bytes_lp-1:0]    byte_mask;
  logic [cce_block_width_p-1:0] old_blk, new_blk, rdata, bit_mask, wdata_shift, rdata_uc;
  logic                         full, we, known;

  always_comb begin
    idx         = cmd_r.header.addr[lg_block_bytes_lp +: lg_els_lp];
    old_blk     = mem_r[idx];
    full        = (cmd_r.header.size >= 3'(lg_block_bytes_lp));
    off         = full ? '0
                : (cmd_r.header.addr[lg_block_bytes_lp-1:0] & ({lg_block_bytes_lp{1'b1}} << cmd_r.header.size));
    byte_mask   = full ? '1
                : (({block_bytes_lp{1'b1}} >> (block_bytes_lp - (1 << cmd_r.header.size))) << off);
    bit_mask    = full ? '1
                : ({cce_block_width_p{1'b1}} >> (cce_block_width_p - (8 << cmd_r.header.size)));
    wdata_shift = cmd_r.data << {off, 3'b000};
    rdata_uc    = (old_blk >> {off, 3'b000}) & bit_mask;
    new_blk     = old_blk;
    rdata       = '0;
    we          = 1'b0;
    known       = 1'b1;
    case (cmd_r.header.msg_type)
      e_mem_msg_rd:    rdata = old_blk;
      e_mem_msg_wr:    begin we = 1'b1; new_blk = cmd_r.data; end
      e_mem_msg_uc_rd: rdata = rdata_uc;
      e_mem_msg_uc_wr: begin
        we = 1'b1;
        for (int b = 0; b < block_bytes_lp; b++)
          if (byte_mask[b]) new_blk[8*b +: 8] = wdata_shift[8*b +: 8];
      end
      default:         known = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      cnt_r  <= '0;
      cmd_r  <= '0;
      resp_r <= '0;
    end else begin
      if (cmd_fire) begin
        cmd_r <= cmd_in;
        cnt_r <= cnt_w_lp'(latency_p - 1);
      end else if ((state_r == e_wait) && (cnt_r != '0)) begin
        cnt_r <= cnt_r - 1'b1;
      end
      if (service) resp_r <= '{data: rdata, header: cmd_r.header};
    end

  // The state register is held in e_ready during reset, so no write can land then.
  always_ff @(posedge clk_i)
    if (service) begin
      if (we) mem_r[idx] <= new_blk;
      assert (known) else $error("mem_responder: unknown msg_type %0d", cmd_r.header.msg_type);
    end

endmodule

// File: tb/tb_bp_me_nonsynth_mem_responder.sv
// Directed bench for bp_me_nonsynth_mem_responder with hand-computed expectations.
module tb_bp_me_nonsynth_mem_responder;

  localparam int W = 566;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [W-1:0]  mem_cmd = '0;
  logic          mem_cmd_v = 1'b0;
  logic          mem_cmd_ready;
  logic [W-1:0]  mem_resp;
  logic          mem_resp_v;
  logic          mem_resp_yumi = 1'b0;

  int n_asserts = 0;
  int n_fail    = 0;

  bp_me_nonsynth_mem_responder dut
    (.clk_i(clk)
    ,.reset_n_i(reset_n)
    ,.mem_cmd_i(mem_cmd)
    ,.mem_cmd_v_i(mem_cmd_v)
    ,.mem_cmd_ready_o(mem_cmd_ready)
    ,.mem_resp_o(mem_resp)
    ,.mem_resp_v_o(mem_resp_v)
    ,.mem_resp_yumi_i(mem_resp_yumi)
    );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [3:0] t, input logic [39:0] a,
                                      input logic [2:0] sz, input logic [6:0] pl,
                                      input logic [511:0] d);
    return {d, pl, sz, a, t};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] c);
    int k = 0;
    while (!mem_cmd_ready && k < 30) begin tick(); k++; end
    chk("ready_wait", W'(mem_cmd_ready), W'(1));
    mem_cmd = c; mem_cmd_v = 1'b1;
    tick();
    mem_cmd_v = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input int exp_lat);
    int n = 0;
    while (!mem_resp_v && n < 30) begin tick(); n++; end
    chk(tag, W'(n), W'(exp_lat));
  endtask

  task automatic yumi();
    mem_resp_yumi = 1'b1;
    tick();
    mem_resp_yumi = 1'b0;
  endtask

  logic [511:0] inc_d, q_d, r_d, b_d;
  logic [W-1:0] c, held;

  initial begin
    for (int i = 0; i < 64; i++) begin
      inc_d[8*i +: 8] = 8'(i);
      q_d[8*i +: 8]   = 8'(i*7 + 3);
      r_d[8*i +: 8]   = 8'(8'hF0 ^ i);
      b_d[8*i +: 8]   = 8'(8'h80 + i);
    end

    // Reset held for 5 cycles
    #1 reset_n = 1'b0;
    repeat (5) tick();
    chk("rst_ready", W'(mem_cmd_ready), W'(0));
    chk("rst_resp_v", W'(mem_resp_v), W'(0));
    chk("rst_resp", mem_resp, '0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_ready", W'(mem_cmd_ready), W'(1));

    // Block write then read at 0x40
    send(mk(4'd1, 40'h40, 3'd6, 7'h11, inc_d));
    wait_resp("wr40_lat", 4);
    chk("wr40_data", W'(mem_resp[565:54]), '0);
    yumi();
    chk("ready_after_yumi", W'(mem_cmd_ready), W'(1));
    c = mk(4'd0, 40'h40, 3'd6, 7'h5A, '0);
    send(c);
    wait_resp("rd40_lat", 4);
    chk("rd40_data", W'(mem_resp[565:54]), W'(inc_d));
    chk("rd40_hdr", W'(mem_resp[53:0]), W'(c[53:0]));
    yumi();

    // Uncached write merge into zero block at 0x80
    send(mk(4'd3, 40'h84, 3'd2, 7'h01, 512'hDEADBEEF));
    wait_resp("ucwr_lat", 4);
    chk("ucwr_data", W'(mem_resp[565:54]), '0);
    yumi();
    send(mk(4'd2, 40'h80, 3'd3, 7'h02, '0));
    wait_resp("ucrd8_lat", 4);
    chk("ucrd8_data", W'(mem_resp[565:54]), W'(64'hDEADBEEF_00000000));
    yumi();
    send(mk(4'd2, 40'h86, 3'd0, 7'h03, '0));
    wait_resp("ucrd1_lat", 4);
    chk("ucrd1_data", W'(mem_resp[565:54]), W'(8'hAD));
    yumi();
    send(mk(4'd2, 40'h87, 3'd1, 7'h04, '0));
    wait_resp("ucrd2_align_lat", 4);
    chk("ucrd2_align_data", W'(mem_resp[565:54]), W'(16'hDEAD));
    yumi();
    send(mk(4'd2, 40'h85, 3'd2, 7'h05, '0));
    wait_resp("ucrd4_align_lat", 4);
    chk("ucrd4_align_data", W'(mem_resp[565:54]), W'(32'hDEADBEEF));
    yumi();
    send(mk(4'd0, 40'h80, 3'd6, 7'h06, '0));
    wait_resp("rd80_lat", 4);
    chk("rd80_block", W'(mem_resp[565:54]), W'(64'hDEADBEEF_00000000));
    yumi();

    // Block-size uncached write behaves as full write
    send(mk(4'd3, 40'h1C0, 3'd6, 7'h07, b_d));
    wait_resp("ucwr_blk_lat", 4);
    yumi();
    send(mk(4'd0, 40'h1C0, 3'd6, 7'h08, '0));
    wait_resp("rd1c0_lat", 4);
    chk("rd1c0_data", W'(mem_resp[565:54]), W'(b_d));
    yumi();

    // Wrap-around: 0x1000 aliases block 0
    send(mk(4'd1, 40'h1000, 3'd6, 7'h09, q_d));
    wait_resp("wr1000_lat", 4);
    yumi();
    c = mk(4'd0, 40'h0, 3'd6, 7'h0A, '0);
    send(c);
    wait_resp("rd0_lat", 4);
    chk("wrap_data", W'(mem_resp[565:54]), W'(q_d));

    // Backpressure: hold the response 10 cycles
    held = {q_d, c[53:0]};
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_resp_stable", mem_resp, held);
      chk("bp_resp_v", W'(mem_resp_v), W'(1));
      chk("bp_ready", W'(mem_cmd_ready), W'(0));
    end
    yumi();
    chk("bp_ready_after", W'(mem_cmd_ready), W'(1));
    chk("bp_resp_v_after", W'(mem_resp_v), W'(0));

    // Mid-op reset discards a pending write to 0x200
    send(mk(4'd1, 40'h200, 3'd6, 7'h0B, r_d));
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_resp_v", W'(mem_resp_v), W'(0));
    chk("midrst_ready", W'(mem_cmd_ready), W'(0));
    tick();
    tick();
    chk("midrst_resp_zero", mem_resp, '0);
    reset_n = 1'b1;
    tick();
    chk("midrst_ready_after", W'(mem_cmd_ready), W'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_no_resp", W'(mem_resp_v), W'(0));
    end
    send(mk(4'd0, 40'h200, 3'd6, 7'h0C, '0));
    wait_resp("rd200_lat", 4);
    chk("rd200_data", W'(mem_resp[565:54]), '0);
    yumi();
    send(mk(4'd0, 40'h40, 3'd6, 7'h0D, '0));
    wait_resp("rd40b_lat", 4);
    chk("rd40_persist", W'(mem_resp[565:54]), W'(inc_d));
    yumi();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
